// File: rtl/accel_step_integrator.sv
// accel_step_integrator: integrates a->v->x on tick and turns x bit-crossings into step/dir pulses.
module accel_step_integrator #(
  parameter int WIDTH     = 64,
  parameter int SB_W      = 6,
  parameter int STEP_LEN  = 4,
  parameter int DIR_SETUP = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    tick,
  input  logic                    set_x,
  input  logic                    set_v,
  input  logic                    set_a,
  input  logic signed [WIDTH-1:0] x_val,
  input  logic signed [WIDTH-1:0] v_val,
  input  logic signed [WIDTH-1:0] a_val,
  input  logic [SB_W-1:0]         step_bit,
  input  logic                    clear_err,
  output logic signed [WIDTH-1:0] x,
  output logic signed [WIDTH-1:0] v,
  output logic signed [WIDTH-1:0] a,
  output logic                    step,
  output logic                    dir,
  output logic                    busy,
  output logic                    missed_step
);
  localparam int SI = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CM = (STEP_LEN > DIR_SETUP) ? STEP_LEN : DIR_SETUP;
  localparam int CW = $clog2(CM + 1);
  typedef enum logic [1:0] {IDLE, SETUP, PULSE} state_t;
  state_t state_q, state_d;
  logic signed [WIDTH-1:0] x_q, x_d, v_q, v_d, a_q, a_d, x_acc, v_acc;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SI-1:0] sb;
  logic step_q, step_d, dir_q, dir_d, pend_q, pend_d, pdir_q, pdir_d, missed_q, missed_d;
  logic ev, ed, launch, ldir;
  assign x_acc = x_q + v_q;
  assign v_acc = v_q + a_q;
  assign x_d = set_x ? x_val : tick ? x_acc : x_q;
  assign v_d = set_v ? v_val : tick ? v_acc : v_q;
  assign a_d = set_a ? a_val : a_q;
  assign sb = (int'(step_bit) > WIDTH - 1) ? SI'(WIDTH - 1) : SI'(step_bit);
  assign ev = tick & ~set_x & (x_q[sb] != x_acc[sb]);
  assign ed = ~v_q[WIDTH-1] & (|v_q);
  assign launch = (state_q == IDLE) & (pend_q | ev);
  assign ldir = pend_q ? pdir_q : ed;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    step_d = step_q;
    dir_d = dir_q;
    pend_d = pend_q;
    pdir_d = pdir_q;
    missed_d = missed_q & ~clear_err;
    case (state_q)
      IDLE: begin
        pend_d = pend_q & ev;
        pdir_d = (pend_q & ev) ? ed : pdir_q;
      end
      SETUP: begin
        step_d = cnt_q == '0;
        state_d = (cnt_q == '0) ? PULSE : SETUP;
        cnt_d = (cnt_q == '0) ? CW'(STEP_LEN - 1) : cnt_q - CW'(1);
      end
      default: begin
        step_d = cnt_q != '0;
        state_d = (cnt_q == '0) ? IDLE : PULSE;
        cnt_d = (cnt_q == '0) ? cnt_q : cnt_q - CW'(1);
      end
    endcase
    // An event arriving mid-sequence is parked; a second one is lost.
    if (state_q != IDLE && ev) begin
      missed_d = missed_d | pend_q;
      pdir_d = pend_q ? pdir_q : ed;
      pend_d = 1'b1;
    end
    if (launch) begin
      step_d = ldir == dir_q;
      dir_d = ldir;
      state_d = (ldir == dir_q) ? PULSE : SETUP;
      cnt_d = (ldir == dir_q) ? CW'(STEP_LEN - 1) : CW'(DIR_SETUP - 1);
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_q <= '0;
      v_q <= '0;
      a_q <= '0;
      state_q <= IDLE;
      cnt_q <= '0;
      step_q <= 1'b0;
      dir_q <= 1'b0;
      pend_q <= 1'b0;
      pdir_q <= 1'b0;
      missed_q <= 1'b0;
    end else begin
      x_q <= x_d;
      v_q <= v_d;
      a_q <= a_d;
      state_q <= state_d;
      cnt_q <= cnt_d;
      step_q <= step_d;
      dir_q <= dir_d;
      pend_q <= pend_d;
      pdir_q <= pdir_d;
      missed_q <= missed_d;
    end
  end
  assign x = x_q;
  assign v = v_q;
  assign a = a_q;
  assign step = step_q;
  assign dir = dir_q;
  assign busy = (state_q != IDLE) | pend_q;
  assign missed_step = missed_q;
endmodule

// File: doc/accel_step_integrator.md
Name: accel_step_integrator

Overview:
- Parametrised successor to the single-axis speed integrator.
- Integrates acceleration into velocity and velocity into position, at a configurable width and on an integration strobe.
- Turns position bit-crossings into step/dir pulses with a programmable pulse width and dir-setup delay.
- Buffers one pending step and flags lost steps. Sits between the motion planner registers and the stepper driver pins.

Parameters:
- WIDTH, 64, width of x, v, a (signed two's complement).
- SB_W, 6, width of step_bit select.
- STEP_LEN, 4, cycles step is held high (>=1).
- DIR_SETUP, 2, cycles between a dir change and the step rising edge (>=1).

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- tick  in  1  integration strobe; x/v integrate only when 1.
- set_x  in  1  load x from x_val.
- set_v  in  1  load v from v_val.
- set_a  in  1  load a from a_val.
- x_val  in  WIDTH  signed position load value.
- v_val  in  WIDTH  signed velocity load value.
- a_val  in  WIDTH  signed acceleration load value.
- step_bit  in  SB_W  index of x bit whose toggle means one step.
- clear_err  in  1  clears missed_step.
- x  out  WIDTH  signed position.
- v  out  WIDTH  signed velocity.
- a  out  WIDTH  signed acceleration.
- step  out  1  step pulse, registered.
- dir  out  1  direction, registered; 1 = positive.
- busy  out  1  pulse sequencer not IDLE, or a step is pending.
- missed_step  out  1  sticky: a step was dropped.

Behaviour:
- Reset (reset=0, asynchronous): x=v=a=0, step=0, dir=0, busy=0, missed_step=0, pending cleared, state IDLE.
- Arithmetic: x_acc = x + v and v_acc = v + a, both computed from current (pre-edge) values, modulo 2^WIDTH, no saturation.
- Wrap-around: occurs silently; a crossing caused by the wrap is a normal step.
- x register each cycle:
  - set_x=1: x <= x_val. No step is detected.
  - else tick=1: x <= x_acc.
  - else: hold.
- v register each cycle:
  - set_v=1: v <= v_val.
  - else tick=1: v <= v_acc.
  - else: hold.
- a register: set_a=1 loads a <= a_val; otherwise hold.
- All set_* inputs act independently of tick.
- Effective bit index: sb = min(step_bit, WIDTH-1).
- Step event: tick=1, set_x=0 and x[sb] != x_acc[sb].
  - Event direction ed = (v > 0) ? 1 : 0, using the pre-edge v.
  - At most one event per cycle. |v| >= 2^sb is out of contract (steps are under-counted, not flagged).
- Sequencer states: IDLE, SETUP, PULSE.
  - IDLE with event (or pending step), ed == dir: on the same edge step<=1, state PULSE, counter=STEP_LEN-1.
  - IDLE with event (or pending), ed != dir: on the same edge dir<=ed, state SETUP, counter=DIR_SETUP-1.
  - SETUP: count down; when counter=0, step<=1, state PULSE, counter=STEP_LEN-1.
  - PULSE: count down; when counter=0, step<=0, state IDLE.
  - A pending step launches from IDLE on the following cycle, so step is low for at least 1 cycle between pulses.
- Latency:
  - Same-dir step rises on the edge that updates x.
  - Dir-change step rises DIR_SETUP cycles after dir changes.
  - dir never changes while step=1.
- Event while not IDLE:
  - No step pending: store it as pending (with its ed).
  - Step already pending: drop it and set missed_step=1.
- Event in IDLE while a step is pending: the pending step launches; the new event becomes pending.
- missed_step clears on clear_err=1 unless a drop occurs in the same cycle (set wins).
- busy = (state != IDLE) | pending.
- set_x while a pulse is in progress does not abort the pulse; pending is kept.

Test Plan:
- Reset: hold reset=0 with random inputs -> all outputs 0. Release and idle 10 cycles -> outputs stay 0.
- Constant velocity, tick=1 every cycle, STEP_LEN=4, DIR_SETUP=2:
  - set_v v_val=64, step_bit=8 -> one step every 4 cycles.
  - First step: dir rises, step rises 2 cycles later, high 4 cycles.
  - x=256 after the 4th tick; missed_step=0.
- Acceleration: set_a a_val=1, v=0, x=0, tick every cycle -> v=n and x=n(n-1)/2 after n ticks. Check x=45 at n=10.
- Direction reversal: v=+128 with a step in flight, then set_v v_val=-128 -> dir falls only after step falls, next step follows DIR_SETUP cycles later with dir=0.
- Overrun: step_bit=0, v=1, tick every cycle, STEP_LEN=4 -> missed_step set during the 3rd event inside the first pulse; clear_err with no events clears it.
- Wrap and load precedence:
  - x=2^63-1, v=1 -> x wraps to -2^63 (step fires at step_bit=63).
  - set_x and tick together -> x=x_val, no step.
  - Async reset mid-PULSE -> step=0 immediately.
